// File: rtl/icache_pkg.sv
// Shared types, widths and address helpers for the instruction cache.
// Address split: {tag[31:10], index[9:4], offset[3:0]}; one 128-bit line per index.
package icache_pkg;

  localparam int unsigned ADDR_WIDTH   = 32;
  localparam int unsigned INDEX_WIDTH  = 6;
  localparam int unsigned OFFSET_WIDTH = 4;
  localparam int unsigned TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int unsigned LINE_WIDTH   = 128;
  localparam int unsigned WORD_WIDTH   = 32;
  localparam int unsigned NUM_LINES    = 1 << INDEX_WIDTH;

  typedef logic [ADDR_WIDTH-1:0]  addr_t;
  typedef logic [INDEX_WIDTH-1:0] index_t;
  typedef logic [TAG_WIDTH-1:0]   tag_t;
  typedef logic [LINE_WIDTH-1:0]  line_t;
  typedef logic [WORD_WIDTH-1:0]  word_t;
  typedef logic [1:0]             word_sel_t;

  // One storage entry: tag plus the line it describes
  typedef struct packed {
    tag_t  tag;
    line_t line;
  } line_entry_t;

  function automatic index_t addr_index(input addr_t a);
    return a[OFFSET_WIDTH +: INDEX_WIDTH];
  endfunction

  function automatic tag_t addr_tag(input addr_t a);
    return a[ADDR_WIDTH-1 -: TAG_WIDTH];
  endfunction

  function automatic addr_t line_addr(input addr_t a);
    return {a[ADDR_WIDTH-1:OFFSET_WIDTH], OFFSET_WIDTH'(0)};
  endfunction

  // Little-endian word pick: word 0 lives in bits [31:0]
  function automatic word_t line_word(input line_t l, input word_sel_t w);
    return l[{w, 5'b0} +: WORD_WIDTH];
  endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-side handshake bundle for the instruction cache.
// slave : cache view (requests in, responses/refill requests out)
// master: environment view (fetch unit, ROB flush and memory controller)
interface icache_if;
  import icache_pkg::*;

  logic  valid_from_ifetch;
  addr_t addr_from_ifetch;
  logic  flush_from_rob;
  logic  ready_to_ifetch;
  word_t inst_to_ifetch;
  logic  valid_to_mem;
  addr_t addr_to_mem;
  logic  ready_from_mem;
  line_t data_from_mem;

  modport slave (
    input  valid_from_ifetch, addr_from_ifetch, flush_from_rob,
    input  ready_from_mem, data_from_mem,
    output ready_to_ifetch, inst_to_ifetch, valid_to_mem, addr_to_mem
  );

  modport master (
    output valid_from_ifetch, addr_from_ifetch, flush_from_rob,
    output ready_from_mem, data_from_mem,
    input  ready_to_ifetch, inst_to_ifetch, valid_to_mem, addr_to_mem
  );

endinterface

// File: rtl/icache_line_ram.sv
// Tag + data storage for the direct-mapped icache.
// Ports: clk; we/waddr/wdata synchronous write; raddr -> rdata_c combinational read.
// Contents are not reset; validity is tracked by the owner.
module icache_line_ram
  import icache_pkg::*;
(
  input  logic        clk,
  input  logic        we,
  input  index_t      waddr,
  input  line_entry_t wdata,
  input  index_t      raddr,
  output line_entry_t rdata_c
);

  line_entry_t mem [NUM_LINES];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache, one outstanding fetch at a time.
// Ports: clk, rst (async, active-high), rdy (global enable / freeze),
//        bus (icache_if.slave): fetch request/response, ROB flush, line refill.
module icache
  import icache_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     rdy,
  icache_if.slave  bus
);

  // DRAIN: refill still in flight but its response was cancelled by a flush
  typedef enum logic [1:0] {IDLE, REFILL, DRAIN} state_e;

  state_e               state_q, state_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic                 ready_q, ready_d;
  word_t                inst_q, inst_d;
  logic                 vmem_q, vmem_d;
  addr_t                amem_q, amem_d;
  word_sel_t            woff_q, woff_d;

  logic        ram_we;
  line_entry_t ram_wdata;
  line_entry_t ram_rd;
  index_t      req_index;
  index_t      refill_index;
  logic        hit;
  logic        unused_addr_bits;

  assign req_index        = addr_index(bus.addr_from_ifetch);
  assign refill_index     = addr_index(amem_q);
  assign ram_wdata        = '{tag: addr_tag(amem_q), line: bus.data_from_mem};
  assign hit              = valid_q[req_index] && (ram_rd.tag == addr_tag(bus.addr_from_ifetch));
  assign unused_addr_bits = ^{bus.addr_from_ifetch[1:0], amem_q[3:0]};

  icache_line_ram u_line_ram (
    .clk     (clk),
    .we      (ram_we),
    .waddr   (refill_index),
    .wdata   (ram_wdata),
    .raddr   (req_index),
    .rdata_c (ram_rd)
  );

  // Next-state and output computation
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    ready_d = 1'b0;
    inst_d  = inst_q;
    vmem_d  = vmem_q;
    amem_d  = amem_q;
    woff_d  = woff_q;
    ram_we  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // No new lookup while the previous response is still on the bus
        if (bus.valid_from_ifetch && !ready_q && !bus.flush_from_rob) begin
          if (hit) begin
            ready_d = 1'b1;
            inst_d  = line_word(ram_rd.line, bus.addr_from_ifetch[3:2]);
          end else begin
            vmem_d  = 1'b1;
            amem_d  = line_addr(bus.addr_from_ifetch);
            woff_d  = bus.addr_from_ifetch[3:2];
            state_d = REFILL;
          end
        end
      end
      REFILL, DRAIN: begin
        if (bus.ready_from_mem) begin
          // Line is installed even when the response is cancelled
          ram_we                = rdy;
          valid_d[refill_index] = 1'b1;
          vmem_d                = 1'b0;
          state_d               = IDLE;
          if (state_q == REFILL && !bus.flush_from_rob) begin
            ready_d = 1'b1;
            inst_d  = line_word(bus.data_from_mem, woff_q);
          end
        end else if (bus.flush_from_rob) begin
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; rdy low freezes everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      ready_q <= 1'b0;
      inst_q  <= '0;
      vmem_q  <= 1'b0;
      amem_q  <= '0;
      woff_q  <= '0;
    end else if (rdy) begin
      state_q <= state_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      inst_q  <= inst_d;
      vmem_q  <= vmem_d;
      amem_q  <= amem_d;
      woff_q  <= woff_d;
    end
  end

  assign bus.ready_to_ifetch = ready_q;
  assign bus.inst_to_ifetch  = inst_q;
  assign bus.valid_to_mem    = vmem_q;
  assign bus.addr_to_mem     = amem_q;

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, read-only instruction cache between the instruction-fetch unit (upstream) and the memory controller's icache port (downstream).
- Serves 32-bit instruction words to fetch.
- On a miss, requests one 16-byte line from the memory controller and installs it.
- Refill traffic and hit responses are strictly serialized: one outstanding fetch at a time.

Parameters:
- INDEX_WIDTH, 6, number of index bits; 2^INDEX_WIDTH lines.
- ADDR_WIDTH, 32, byte-address width.
- OFFSET_WIDTH, 4, line-offset bits (16-byte line, 128-bit line bus).
- TAG_WIDTH, ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH (22), stored tag width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rdy  in  1  global enable; when low, all state holds
- valid_from_ifetch  in  1  fetch request valid
- addr_from_ifetch  in  32  fetch byte address; bits [1:0] ignored
- flush_from_rob  in  1  pipeline flush; cancels any pending response
- ready_to_ifetch  out  1  one-cycle pulse; inst_to_ifetch valid
- inst_to_ifetch  out  32  fetched instruction word
- valid_to_mem  out  1  line refill request
- addr_to_mem  out  32  line address {tag,index,4'b0}
- ready_from_mem  in  1  one-cycle pulse; line data valid this cycle
- data_from_mem  in  128  refilled line, byte 0 in bits [7:0]

Behaviour:
- Reset (async, rst=1): all line valid bits cleared; state=IDLE; ready_to_ifetch=0, inst_to_ifetch=0, valid_to_mem=0, addr_to_mem=0. Tag and data arrays are not reset. Reset mid-refill abandons the refill.
- rdy=0: no register changes, including outputs and arrays. Memory-side pulses arriving while rdy=0 are not required to be captured; the controller is frozen by the same rdy.
- Fetch contract:
  - valid_from_ifetch and addr_from_ifetch must be held stable until ready_to_ifetch pulses or flush_from_rob is asserted.
  - A new request is sampled only in IDLE when ready_to_ifetch is not asserted this cycle.
- FSM IDLE:
  - Request sampled. Lookup index = addr[9:4], tag = addr[31:10].
  - Hit (valid[index] and tag match): next cycle ready_to_ifetch=1 and inst_to_ifetch = line word addr[3:2]. Word 0 is bits [31:0], little-endian. Stay IDLE.
  - Hit latency: 1 cycle.
  - Miss: next cycle valid_to_mem=1 and addr_to_mem = {addr[31:4], 4'b0}. Go to REFILL.
- FSM REFILL:
  - valid_to_mem and addr_to_mem are held constant; the controller reads the address live during the transfer.
  - On ready_from_mem=1:
    - Write data_from_mem into data[index], write the tag, set valid[index].
    - Next cycle: valid_to_mem=0, ready_to_ifetch=1, inst_to_ifetch = word of data_from_mem (forwarded, not re-read). State goes to IDLE.
  - valid_to_mem must be low in the cycle after ready_from_mem; the controller blocks icache re-acceptance for exactly that cycle.
- ready_to_ifetch: always a single-cycle pulse, cleared the following cycle.
- Flush:
  - flush_from_rob=1 in IDLE: suppresses any response that would assert next cycle.
  - flush_from_rob=1 in REFILL: the refill continues to completion (the memory transfer cannot be aborted) and the line is installed. State goes to a DRAIN mark so that no ready_to_ifetch is produced for it.
  - New requests are ignored until back in IDLE.
  - A flush coinciding with ready_from_mem: the line is installed and no response is issued.
- Same-index replacement: the line is overwritten unconditionally; there is no dirty state.
- A request arriving in the same cycle as the refill response pulse is not sampled; it is sampled the next cycle.

Decomposition:
- Shared macros in config.v: ADDR_TYPE, CACHE_LINE_TYPE, CACHE_TAG_AND_INDEX_RANGE, BYTE_TYPE, and a new ICACHE_INDEX_RANGE / ICACHE_TAG_RANGE pair.
- The FSM state encoding is a localparam inside the module.
- One natural sub-module: icache_line_ram, the tag+data storage.
  - Synchronous write port.
  - Combinational read port: index in, {tag,line} out.
  - The valid bits stay in icache, so they can be reset asynchronously.

Test Plan:
- Cold miss: reset, fetch 0x0000_0104.
  - Required: valid_to_mem=1 with addr_to_mem=0x0000_0100, held until the mem model pulses ready_from_mem with line 0x33221100_77665544_BBAA9988_FFEEDDCC (word1=0xBBAA9988, words 3..0 listed MSW first).
  - Next cycle: ready_to_ifetch=1, inst=0xBBAA9988, valid_to_mem=0.
- Hit: fetch 0x0000_010C after the line above is installed → ready_to_ifetch one cycle later, inst=0x33221100, valid_to_mem stays 0.
- Conflict eviction: fetch 0x0000_0500 (same index 0x10, different tag) → refill issued at 0x500. Then re-fetching 0x104 misses again with addr_to_mem=0x100.
- Flush during refill: miss on 0x2000, assert flush_from_rob 3 cycles into REFILL.
  - Required: valid_to_mem held until ready_from_mem; no ready_to_ifetch pulse.
  - A subsequent fetch of 0x2000 hits with 1-cycle latency.
- rdy stall: deassert rdy for 5 cycles mid-REFILL and during a hit response → outputs frozen, response delivered exactly once after rdy returns.
- Async reset mid-refill: pulse rst between clock edges during REFILL.
  - Required: valid_to_mem=0 immediately.
  - The previously installed 0x100 line is now a miss on refetch.
